tff_counter: RTL and testbench

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_counter.sv | 105 ++++++++++
 tb/tb_tff_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// tff_counter: modulo up/down counter with parallel load, per-bit T-flop toggle mode and sticky wrap flag.
// Latency: one active clk edge (NEGEDGE=1 falling, 0 rising) from inputs to registered q/tc/ovf.
// No backpressure; en gates counting. Define TFF_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module tff_counter #(
   parameter int              WIDTH   = 8,
   parameter longint unsigned MODULUS = 256,
   parameter int              NEGEDGE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t_mask,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_TOGGLE = 2'b11;

   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;

   always_comb begin
      q_nxt  = q;
      tc_nxt = 1'b0;
      if (load) begin
         q_nxt = load_val;
      end else if (en) begin
         case (mode)
            MODE_UP: begin
               if (q >= TOP) begin
`ifdef TFF_COUNTER_SAT_EN
                  q_nxt = TOP;
`else
                  q_nxt = '0;
`endif
                  tc_nxt = 1'b1;
               end else begin
                  q_nxt = q + ONE;
               end
            end
            MODE_DOWN: begin
               if (q == '0) begin
`ifdef TFF_COUNTER_SAT_EN
                  q_nxt = '0;
`else
                  q_nxt = TOP;
`endif
                  tc_nxt = 1'b1;
               end else if (q > TOP) begin
                  // An out-of-range loaded value snaps into range without counting as a wrap.
                  q_nxt = TOP;
               end else begin
                  q_nxt = q - ONE;
               end
            end
            MODE_TOGGLE: q_nxt = q ^ t_mask;
            MODE_HOLD:   q_nxt = q;
            default:     q_nxt = q;
         endcase
      end
      // A wrap in the same edge as clr_ovf keeps the flag set.
      ovf_nxt = tc_nxt | (ovf & ~clr_ovf);
   end

   generate
      if (NEGEDGE != 0) begin : g_fall
         always_ff @(negedge clk) begin
            if (reset) begin
               q   <= '0;
               tc  <= 1'b0;
               ovf <= 1'b0;
            end else begin
               q   <= q_nxt;
               tc  <= tc_nxt;
               ovf <= ovf_nxt;
            end
         end
      end else begin : g_rise
         always_ff @(posedge clk) begin
            if (reset) begin
               q   <= '0;
               tc  <= 1'b0;
               ovf <= 1'b0;
            end else begin
               q   <= q_nxt;
               tc  <= tc_nxt;
               ovf <= ovf_nxt;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: falling-edge and rising-edge instances (WIDTH=4, MODULUS=10) checked against a behavioural model.
module tb_tff_counter;

   localparam int W = 4;
   localparam int M = 10;
`ifdef TFF_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         n_reset, n_en, n_load, n_clr;
   logic [W-1:0] n_lv, n_tm, n_q;
   logic [1:0]   n_mode;
   logic         n_tc, n_ovf;

   logic         p_reset, p_en, p_load, p_clr;
   logic [W-1:0] p_lv, p_tm, p_q;
   logic [1:0]   p_mode;
   logic         p_tc, p_ovf;

   int checks = 0;
   int passes = 0;

   int mq_n = 0, mq_p = 0;
   bit movf_n = 0, movf_p = 0;
   bit known_n = 0, known_p = 0;

   tff_counter #(.WIDTH(W), .MODULUS(M), .NEGEDGE(1)) dut_n (
      .clk(clk), .reset(n_reset), .en(n_en), .load(n_load), .load_val(n_lv),
      .mode(n_mode), .t_mask(n_tm), .clr_ovf(n_clr), .q(n_q), .tc(n_tc), .ovf(n_ovf));

   tff_counter #(.WIDTH(W), .MODULUS(M), .NEGEDGE(0)) dut_p (
      .clk(clk), .reset(p_reset), .en(p_en), .load(p_load), .load_val(p_lv),
      .mode(p_mode), .t_mask(p_tm), .clr_ovf(p_clr), .q(p_q), .tc(p_tc), .ovf(p_ovf));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Behavioural model of one active edge, straight from the counting rules.
   function automatic void ref_next(input int q, input bit ovf, input bit rst, input bit ld,
                                    input bit e, input int lv, input logic [1:0] md, input int tm,
                                    input bit clr, output int qn, output bit tcn, output bit ovfn);
      int top;
      top  = M - 1;
      qn   = q;
      tcn  = 1'b0;
      ovfn = ovf && !clr;
      if (rst) begin
         qn = 0; tcn = 0; ovfn = 0;
         return;
      end
      if (ld) qn = lv;
      else if (e) begin
         if (md == 2'd1) begin
            if (q < top) qn = q + 1;
            else begin qn = SAT ? top : 0; tcn = 1; end
         end else if (md == 2'd2) begin
            if (q == 0) begin qn = SAT ? 0 : top; tcn = 1; end
            else if (q > top) qn = top;
            else qn = q - 1;
         end else if (md == 2'd3) begin
            qn = (q ^ tm) % (1 << W);
         end
      end
      if (tcn) ovfn = 1'b1;
   endfunction

   task automatic set_n(input bit rst, input bit ld, input int lv, input bit e,
                        input int md, input int tm, input bit clr);
      n_reset = rst; n_load = ld; n_lv = W'(lv); n_en = e;
      n_mode = 2'(md); n_tm = W'(tm); n_clr = clr;
   endtask

   task automatic set_p(input bit rst, input bit ld, input int lv, input bit e,
                        input int md, input int tm, input bit clr);
      p_reset = rst; p_load = ld; p_lv = W'(lv); p_en = e;
      p_mode = 2'(md); p_tm = W'(tm); p_clr = clr;
   endtask

   task automatic edge_n(input string tag);
      int qn; bit tcn, ovfn;
      #1;
      if (known_n) chk({tag, ".hold_q"}, int'(n_q), mq_n);
      ref_next(mq_n, movf_n, n_reset, n_load, n_en, int'(n_lv), n_mode, int'(n_tm), n_clr, qn, tcn, ovfn);
      @(negedge clk); #1;
      mq_n = qn; movf_n = ovfn;
      if (n_reset) known_n = 1'b1;
      if (known_n) begin
         chk({tag, ".q"},   int'(n_q),   qn);
         chk({tag, ".tc"},  int'(n_tc),  int'(tcn));
         chk({tag, ".ovf"}, int'(n_ovf), int'(ovfn));
      end
   endtask

   task automatic edge_p(input string tag);
      int qn; bit tcn, ovfn;
      #1;
      if (known_p) chk({tag, ".hold_q"}, int'(p_q), mq_p);
      ref_next(mq_p, movf_p, p_reset, p_load, p_en, int'(p_lv), p_mode, int'(p_tm), p_clr, qn, tcn, ovfn);
      @(posedge clk); #1;
      mq_p = qn; movf_p = ovfn;
      if (p_reset) known_p = 1'b1;
      if (known_p) begin
         chk({tag, ".q"},   int'(p_q),   qn);
         chk({tag, ".tc"},  int'(p_tc),  int'(tcn));
         chk({tag, ".ovf"}, int'(p_ovf), int'(ovfn));
      end
   endtask

   initial begin
      set_n(1, 0, 0, 0, 0, 0, 0);
      set_p(1, 0, 0, 0, 0, 0, 0);

      // Reset state, then twelve up-counts through one wrap.
      edge_n("rst");
      chk("rst.q_const", int'(n_q), 0);
      set_n(0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 12; i++) edge_n("up");

      // Load 0 then count down: wrap to top, then decrement.
      set_n(0, 1, 0, 1, 2, 0, 0);
      edge_n("ld0");
      set_n(0, 0, 0, 1, 2, 0, 0);
      edge_n("dn_wrap");
      edge_n("dn");

      // Toggle mode, then hold with en low.
      set_n(0, 1, 5, 1, 3, 3, 0);
      edge_n("ld5");
      set_n(0, 0, 0, 1, 3, 3, 0);
      edge_n("tog");
      chk("tog.q_const", int'(n_q), 6);
      set_n(0, 0, 0, 0, 3, 3, 0);
      edge_n("tog_hold");

      // Out-of-range loaded value counted up and down.
      set_n(0, 1, 14, 0, 0, 0, 0);
      edge_n("ld14");
      set_n(0, 0, 0, 1, 1, 0, 0);
      edge_n("up14");
      set_n(0, 1, 14, 0, 0, 0, 0);
      edge_n("ld14b");
      set_n(0, 0, 0, 1, 2, 0, 0);
      edge_n("dn14");

      // clr_ovf coinciding with a wrap, then a plain clear.
      set_n(0, 1, 9, 0, 0, 0, 1);
      edge_n("ld9_clr");
      set_n(0, 0, 0, 1, 1, 0, 1);
      edge_n("wrap_clr");
      set_n(0, 0, 0, 0, 0, 0, 1);
      edge_n("clr");

      // Reset beats load.
      set_n(0, 1, 3, 0, 0, 0, 0);
      edge_n("ld3");
      set_n(1, 1, 7, 1, 1, 0, 0);
      edge_n("rst_ld");

      // Reset pulsed between falling edges has no effect.
      set_n(0, 0, 0, 1, 1, 0, 0);
      edge_n("pre_pulse");
      @(posedge clk);
      n_reset = 1'b1;
      #2 n_reset = 1'b0;
      edge_n("pulse");

      for (int i = 0; i < 200; i++) begin
         set_n($urandom_range(31) == 0, $urandom_range(7) == 0, int'($urandom_range(15)),
               $urandom_range(3) != 0, int'($urandom_range(3)), int'($urandom_range(15)),
               $urandom_range(7) == 0);
         edge_n("rnd_n");
      end

      // Rising-edge instance: reset, load top, three up-counts.
      @(negedge clk); #1;
      set_p(1, 0, 0, 0, 0, 0, 0);
      edge_p("p_rst");
      set_p(0, 1, 9, 0, 0, 0, 0);
      edge_p("p_ld9");
      set_p(0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) edge_p("p_up");
      for (int i = 0; i < 60; i++) begin
         set_p($urandom_range(31) == 0, $urandom_range(7) == 0, int'($urandom_range(15)),
               $urandom_range(3) != 0, int'($urandom_range(3)), int'($urandom_range(15)),
               $urandom_range(7) == 0);
         edge_p("rnd_p");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
